// File: rtl/hub75_bcm_driver_if.sv
// Host-side port of the HUB75 BCM driver: back-buffer write strobe and
// frame swap handshake. The host drives through the master modport and the
// driver receives through the slave modport.
interface hub75_bcm_driver_if #(
  parameter int ADDR_W      = 13,
  parameter int COLOR_DEPTH = 6
) ();
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [3*COLOR_DEPTH-1:0] wr_data;
  logic                     frame_swap_req;
  logic                     frame_swap_ack;

  modport master (
    output wr_en, wr_addr, wr_data, frame_swap_req,
    input  frame_swap_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, frame_swap_req,
    output frame_swap_ack
  );
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel driver with a double-buffered framebuffer and binary-coded
// modulation. The scan runs row-outer / bitplane-inner. Each bitplane shifts
// one column pair per two clocks, blanks around the row-address change,
// latches, then shows for BASE_TIME<<b cycles.
//
// Optional feature macro: HUB75_BRIGHTNESS_EN
//   When defined, the SHOW on-time of each bitplane is scaled by
//   (brightness+1)/256, with brightness latched at frame_start.
//   When undefined, the brightness port is ignored.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SHIFT    | 2*WIDTH cycles; even = data set up, odd = panel_clk high
// BLANK    | DEADTIME cycles; data/clk low, row address updated
// LATCH    | 1 cycle; panel_stb high
// SHOW     | BASE_TIME<<b cycles; panel_oe low for first on_cnt cycles
//
// Each framebuffer half (top rows / bottom rows) lives in its own memory, so
// both panel halves can be read in one cycle. Each memory holds both buffers:
// buffer 0 occupies the lower half of its index range and buffer 1 the upper.
// The read address is computed from the next-state values, which hides the
// one-cycle memory read latency from the pins.
module hub75_bcm_driver #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 48,
  parameter int SCAN_ROWS   = 24,
  parameter int COLOR_DEPTH = 6,
  parameter int BASE_TIME   = 4,
  parameter int DEADTIME    = 2,
  parameter int ADDR_W      = 13
) (
  input  logic              display_clock,
  input  logic              display_rst_n,
  hub75_bcm_driver_if.slave host,
  input  logic [7:0]        brightness,
  output logic              frame_start,
  output logic              panel_r0,
  output logic              panel_g0,
  output logic              panel_b0,
  output logic              panel_r1,
  output logic              panel_g1,
  output logic              panel_b1,
  output logic              panel_a,
  output logic              panel_b,
  output logic              panel_c,
  output logic              panel_d,
  output logic              panel_e,
  output logic              panel_clk,
  output logic              panel_stb,
  output logic              panel_oe
);

  localparam int PIX_HALF  = SCAN_ROWS * WIDTH;
  localparam int PIX_TOTAL = WIDTH * HEIGHT;
  localparam int SHIFT_LEN = 2 * WIDTH;
  localparam int SHOW_MAX  = BASE_TIME << (COLOR_DEPTH - 1);
  localparam int CNT_A     = (SHIFT_LEN > SHOW_MAX) ? SHIFT_LEN : SHOW_MAX;
  localparam int CNT_MAX   = (CNT_A > DEADTIME) ? CNT_A : DEADTIME;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int ROW_W     = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
  localparam int PLANE_W   = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam int MEM_W     = $clog2(2 * PIX_HALF);
  localparam int PIX_W     = 3 * COLOR_DEPTH;

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_BLANK = 2'd1,
    ST_LATCH = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ROW_W-1:0]   row, row_d;
  logic [PLANE_W-1:0] plane, plane_d;
  logic               front, front_d;
  logic               pending;
  logic               run;
  logic [4:0]         row_addr;

  logic [CNT_W-1:0]   show_len;
  logic [CNT_W:0]     on_cnt;
  logic               last_plane, last_row, show_done, frame_end, swap;

  logic [PIX_W-1:0]   mem_top [2*PIX_HALF];
  logic [PIX_W-1:0]   mem_bot [2*PIX_HALF];
  logic [PIX_W-1:0]   rd_top, rd_bot;
  logic [MEM_W-1:0]   rd_addr;
  logic               wr_hit, wr_top;
  logic [MEM_W-1:0]   wr_idx;

  assign show_len   = CNT_W'(BASE_TIME) << plane;
  assign last_plane = (plane == PLANE_W'(COLOR_DEPTH - 1));
  assign last_row   = (row == ROW_W'(SCAN_ROWS - 1));
  assign show_done  = run && (state == ST_SHOW) && (cnt == show_len - 1'b1);
  assign frame_end  = show_done && last_plane && last_row;
  assign swap       = frame_end && (pending || host.frame_swap_req);
  assign host.frame_swap_ack = swap;

`ifdef HUB75_BRIGHTNESS_EN
  localparam int PROD_W = CNT_W + 9;
  logic [7:0]        bright_q;
  logic [PROD_W-1:0] on_prod;
  assign on_prod = PROD_W'(show_len) * PROD_W'({1'b0, bright_q} + 9'd1);
  assign on_cnt  = on_prod[PROD_W-1:8];
`else
  logic [7:0] unused_brightness;
  assign unused_brightness = brightness;
  assign on_cnt = {1'b0, show_len};
`endif

  // State, scan position, buffer select and swap bookkeeping.
  always_ff @(posedge display_clock) begin
    if (!display_rst_n) begin
      run      <= 1'b0;
      state    <= ST_SHIFT;
      cnt      <= '0;
      row      <= '0;
      plane    <= '0;
      front    <= 1'b0;
      pending  <= 1'b0;
      row_addr <= '0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q <= '0;
`endif
    end else begin
      run     <= 1'b1;
      state   <= state_d;
      cnt     <= cnt_d;
      row     <= row_d;
      plane   <= plane_d;
      front   <= front_d;
      pending <= (pending || host.frame_swap_req) && !swap;
      if (run && (state == ST_SHIFT) && (state_d == ST_BLANK))
        row_addr <= 5'(row);
`ifdef HUB75_BRIGHTNESS_EN
      if (frame_start)
        bright_q <= brightness;
`endif
    end
  end

  // Next-state: phase sequencing and row/bitplane/buffer advance.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    row_d   = row;
    plane_d = plane;
    front_d = front;
    if (run) begin
      case (state)
        ST_SHIFT: begin
          if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt == CNT_W'(DEADTIME - 1)) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          if (show_done) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            if (last_plane) begin
              plane_d = '0;
              row_d   = last_row ? '0 : row + 1'b1;
            end else begin
              plane_d = plane + 1'b1;
            end
            front_d = front ^ swap;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: state_d = ST_SHIFT;
      endcase
    end
  end

  // Read address for the pixel pair shown next cycle; column 0 is prefetched
  // outside SHIFT so the first even cycle already has its data.
  always_comb begin
    logic [MEM_W-1:0] col_d;
    col_d = '0;
    if (state_d == ST_SHIFT)
      col_d = MEM_W'(cnt_d >> 1);
    rd_addr = MEM_W'(row_d) * MEM_W'(WIDTH) + col_d
            + (front_d ? MEM_W'(PIX_HALF) : MEM_W'(0));
  end

  // Host write decode into the back buffer (the one not being displayed).
  always_comb begin
    wr_hit = host.wr_en && (32'(host.wr_addr) < PIX_TOTAL);
    wr_top = (32'(host.wr_addr) < PIX_HALF);
    wr_idx = wr_top ? MEM_W'(host.wr_addr) : MEM_W'(32'(host.wr_addr) - PIX_HALF);
    if (!front)
      wr_idx = wr_idx + MEM_W'(PIX_HALF);
  end

  // Framebuffer memories: one write port, one registered read port each.
  always_ff @(posedge display_clock) begin
    if (wr_hit && wr_top)
      mem_top[wr_idx] <= host.wr_data;
    if (wr_hit && !wr_top)
      mem_bot[wr_idx] <= host.wr_data;
    rd_top <= mem_top[rd_addr];
    rd_bot <= mem_bot[rd_addr];
  end

  // Panel pin decode from the current phase.
  always_comb begin
    logic [COLOR_DEPTH-1:0] tr, tg, tb, br, bg, bb;
    tr = rd_top[COLOR_DEPTH-1:0];
    tg = rd_top[2*COLOR_DEPTH-1:COLOR_DEPTH];
    tb = rd_top[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
    br = rd_bot[COLOR_DEPTH-1:0];
    bg = rd_bot[2*COLOR_DEPTH-1:COLOR_DEPTH];
    bb = rd_bot[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
    frame_start = 1'b0;
    panel_clk   = 1'b0;
    panel_stb   = 1'b0;
    panel_oe    = 1'b1;
    panel_r0    = 1'b0;
    panel_g0    = 1'b0;
    panel_b0    = 1'b0;
    panel_r1    = 1'b0;
    panel_g1    = 1'b0;
    panel_b1    = 1'b0;
    if (run) begin
      case (state)
        ST_SHIFT: begin
          panel_clk   = cnt[0];
          frame_start = (cnt == '0) && (row == '0) && (plane == '0);
          panel_r0    = tr[plane];
          panel_g0    = tg[plane];
          panel_b0    = tb[plane];
          panel_r1    = br[plane];
          panel_g1    = bg[plane];
          panel_b1    = bb[plane];
        end
        ST_LATCH: panel_stb = 1'b1;
        ST_SHOW:  panel_oe  = !({1'b0, cnt} < on_cnt);
        default: ;
      endcase
    end
  end

  assign {panel_e, panel_d, panel_c, panel_b, panel_a} = row_addr;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver on a 4x4 panel, 2 scan rows, 2 bitplanes.
// Frame schedule (68 cycles): per row, bitplane 0 takes 15 cycles
// (SHIFT 0-7, BLANK 8-9, LATCH 10, SHOW 11-14) and bitplane 1 takes 19
// (SHIFT 0-7, BLANK 8-9, LATCH 10, SHOW 11-18).
module tb_hub75_bcm_driver;
  localparam int W = 4, H = 4, SR = 2, CD = 2, BT = 4, DT = 2, AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] brightness;
  logic frame_start;
  logic r0, g0, b0, r1, g1, b1;
  logic pa, pb, pc, pd, pe;
  logic pclk, stb, oe;

  hub75_bcm_driver_if #(.ADDR_W(AW), .COLOR_DEPTH(CD)) bus ();

  hub75_bcm_driver #(
    .WIDTH(W), .HEIGHT(H), .SCAN_ROWS(SR), .COLOR_DEPTH(CD),
    .BASE_TIME(BT), .DEADTIME(DT), .ADDR_W(AW)
  ) dut (
    .display_clock(clk),
    .display_rst_n(rst_n),
    .host(bus),
    .brightness(brightness),
    .frame_start(frame_start),
    .panel_r0(r0), .panel_g0(g0), .panel_b0(b0),
    .panel_r1(r1), .panel_g1(g1), .panel_b1(b1),
    .panel_a(pa), .panel_b(pb), .panel_c(pc), .panel_d(pd), .panel_e(pe),
    .panel_clk(pclk),
    .panel_stb(stb),
    .panel_oe(oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [3*CD-1:0] data;
  } wr_t;

  wr_t             wq[$];
  wr_t             w;
  logic [3*CD-1:0] img  [16];
  logic [3*CD-1:0] img0 [16];
  logic [3*CD-1:0] img1 [16];
  logic [7:0]      cur_br;
  int              vectors = 0;
  int              miscompares = 0;

  // {frame_start, ack, oe, stb, clk, addr[4:0], r0,g0,b0,r1,g1,b1}
  function automatic logic [15:0] observe();
    return {frame_start, bus.frame_swap_ack, oe, stb, pclk,
            pe, pd, pc, pb, pa, r0, g0, b0, r1, g1, b1};
  endfunction

  function automatic int on_len(input int plane);
`ifdef HUB75_BRIGHTNESS_EN
    case (cur_br)
      8'd255:  return (plane == 1) ? 8 : 4;
      8'd127:  return (plane == 1) ? 4 : 2;
      8'd0:    return 0;
      default: return -1;
    endcase
`else
    return (plane == 1) ? 8 : 4;
`endif
  endfunction

  function automatic logic [15:0] expect_vec(input int t, input bit first, input bit ack_e);
    int row, u, plane, ph, k, col, arow;
    logic [5:0] top, bot, data;
    logic clk_e, stb_e, oe_e;
    row = t / 34;
    u = t % 34;
    plane = 0;
    if (u >= 15) begin plane = 1; u = u - 15; end
    if (u < 8)       begin ph = 0; k = u; end
    else if (u < 10) begin ph = 1; k = u - 8; end
    else if (u == 10) begin ph = 2; k = 0; end
    else             begin ph = 3; k = u - 11; end
    clk_e = (ph == 0) && (k % 2 == 1);
    stb_e = (ph == 2);
    oe_e  = !((ph == 3) && (k < on_len(plane)));
    if (ph == 0 && plane == 0) arow = (row == 0) ? (first ? 0 : 1) : row - 1;
    else arow = row;
    data = '0;
    if (ph == 0) begin
      col = k / 2;
      top = img[row*4 + col] >> plane;
      bot = img[(row+2)*4 + col] >> plane;
      data = {top[0], top[2], top[4], bot[0], bot[2], bot[4]};
    end
    return {(t == 0), ack_e, oe_e, stb_e, clk_e, 5'(arow), data};
  endfunction

  task automatic check_idle(input string tag);
    logic [15:0] obs;
    obs = observe();
    vectors++;
    assert (obs === 16'h2000) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, 16'h2000);
    end
  endtask

  task automatic run_frame(input string tag, input int ncyc, input bit first,
                           input bit chk_data, input int req_a, input int req_b,
                           input bit exp_ack);
    logic [15:0] obs, want;
    int rises[4];
    int acks;
    logic prev_clk;
    wr_t cw;
    acks = 0;
    prev_clk = 1'b0;
    for (int g = 0; g < 4; g++) rises[g] = 0;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      brightness = cur_br;
      bus.frame_swap_req = (t == req_a) || (t == req_b);
      if (wq.size() > 0) begin
        cw = wq.pop_front();
        bus.wr_en = 1'b1;
        bus.wr_addr = cw.addr;
        bus.wr_data = cw.data;
      end else begin
        bus.wr_en = 1'b0;
      end
      #1;
      obs = observe();
      want = expect_vec(t, first, exp_ack && (t == 67));
      if (!chk_data) begin
        obs[5:0] = '0;
        want[5:0] = '0;
      end
      vectors++;
      assert (obs === want) else begin
        miscompares++;
        $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, want);
      end
      if (obs[11] && !prev_clk) rises[(t/34)*2 + (((t%34) >= 15) ? 1 : 0)]++;
      prev_clk = obs[11];
      acks += int'(obs[14]);
    end
    if (ncyc == 68) begin
      for (int g = 0; g < 4; g++) begin
        vectors++;
        assert (rises[g] === 4) else begin
          miscompares++;
          $error("FAIL %s clk_rises plane_slot=%0d observed=%0d expected=4", tag, g, rises[g]);
        end
      end
      vectors++;
      assert (acks === (exp_ack ? 1 : 0)) else begin
        miscompares++;
        $error("FAIL %s ack_count observed=%0d expected=%0d", tag, acks, exp_ack ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cur_br = 8'd255;
    brightness = cur_br;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.frame_swap_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      img0[i] = '0;
      img1[i] = '0;
      img[i]  = '0;
    end
    img1[1]  = 6'b000011;  // pixel(0,1) R=3
    img1[9]  = 6'b000100;  // pixel(2,1) G=1
    img0[6]  = 6'b100000;  // pixel(1,2) B=2
    img0[15] = 6'b000001;  // pixel(3,3) R=1

    @(negedge clk);
    check_idle("reset_idle");
    @(negedge clk);
    check_idle("reset_idle_hold");
    rst_n = 1'b1;

    // Frame 1: front buffer 0 (unknown contents), load buffer 1, two requests.
    for (int i = 0; i < 16; i++) begin
      w.addr = AW'(i);
      w.data = img1[i];
      wq.push_back(w);
    end
    run_frame("frame1", 68, 1'b1, 1'b0, 30, 40, 1'b1);

    // Frame 2: shows buffer 1; out-of-range write, load buffer 0, req on last cycle.
    img = img1;
    cur_br = 8'd127;
    w.addr = AW'(16);
    w.data = 6'b111111;
    wq.push_back(w);
    for (int i = 0; i < 16; i++) begin
      w.addr = AW'(i);
      w.data = img0[i];
      wq.push_back(w);
    end
    run_frame("frame2", 68, 1'b0, 1'b1, 67, -1, 1'b1);

    // Frame 3: shows buffer 0; mid-frame request swaps at frame end.
    img = img0;
    cur_br = 8'd0;
    run_frame("frame3", 68, 1'b0, 1'b1, 20, -1, 1'b1);

    // Frame 4: shows buffer 1; pending request, then reset mid-SHOW.
    img = img1;
    cur_br = 8'd255;
    run_frame("frame4_pre_reset", 13, 1'b0, 1'b1, 5, -1, 1'b0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.frame_swap_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_show");
    @(negedge clk);
    check_idle("reset_mid_show_hold");
    rst_n = 1'b1;

    // Frame 5: front back to buffer 0, contents retained, pending cleared.
    img = img0;
    cur_br = 8'd127;
    run_frame("frame5_after_reset", 68, 1'b1, 1'b1, -1, -1, 1'b0);

    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.frame_swap_req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
